// File: rtl/mul_div_unit_pkg.sv
// Shared constants and op-code helpers for the iterative multiply/divide unit.
package mul_div_unit_pkg;

    localparam int WORD = 64;

    localparam logic [2:0] MD_MUL   = 3'd0;
    localparam logic [2:0] MD_SMULH = 3'd1;
    localparam logic [2:0] MD_UMULH = 3'd2;
    localparam logic [2:0] MD_SDIV  = 3'd3;
    localparam logic [2:0] MD_UDIV  = 3'd4;

    // Signed ops run on magnitudes and re-apply the sign at fix-up.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MD_SMULH) || (op == MD_SDIV);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_SDIV) || (op == MD_UDIV);
    endfunction

endpackage

// File: rtl/mul_div_unit_md_abs_negate.sv
// Conditional two's complement: used for operand magnitudes and result sign fix-up.
module md_abs_negate #(
    parameter int WIDTH = 64
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] value_in,
    output logic [WIDTH-1:0] value_out
);

    // Negate when requested; zero maps to zero so the sign of 0 never shows.
    always_comb begin
        value_out = neg ? (~value_in + WIDTH'(1)) : value_in;
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit: MUL, SMULH, UMULH, SDIV, UDIV.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; result holds last value
// S_ITER  | one shift-add / shift-subtract step per cycle, WIDTH steps
// S_FIXUP | apply result sign, select output field, register result
// S_DONE  | done pulse; a start here is accepted back-to-back
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = WORD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ITER  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic               sign_q, sign_d;
    logic               div_zero_q, div_zero_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] fix_in, fix_out;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   quotient;

    md_abs_negate #(.WIDTH(WIDTH)) u_abs_a (
        .neg       (is_signed_op(op) & operand_a[WIDTH-1]),
        .value_in  (operand_a),
        .value_out (abs_a)
    );

    md_abs_negate #(.WIDTH(WIDTH)) u_abs_b (
        .neg       (is_signed_op(op) & operand_b[WIDTH-1]),
        .value_in  (operand_b),
        .value_out (abs_b)
    );

    md_abs_negate #(.WIDTH(2*WIDTH)) u_fix (
        .neg       (sign_q),
        .value_in  (fix_in),
        .value_out (fix_out)
    );

    // Datapath step terms and fix-up operand selection.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff = rem_sh - {1'b0, opnd_q};
        // Restoring division by zero would give all ones; force 0 instead.
        quotient = div_zero_q ? '0 : acc_q[WIDTH-1:0];
        fix_in   = is_div_op(op_q) ? {{WIDTH{1'b0}}, quotient} : acc_q;
    end

    // Next-state and next-datapath computation.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sign_d     = sign_q;
        div_zero_d = div_zero_q;
        count_d    = count_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        result_d   = result_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d    = S_ITER;
                    busy_d     = 1'b1;
                    op_d       = op;
                    sign_d     = is_signed_op(op) & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                    div_zero_d = (operand_b == '0);
                    count_d    = '0;
                    if (is_div_op(op)) begin
                        opnd_d = abs_b;
                        acc_d  = {{WIDTH{1'b0}}, abs_a};
                    end else begin
                        opnd_d = abs_a;
                        acc_d  = {{WIDTH{1'b0}}, abs_b};
                    end
                end
            end
            S_ITER: begin
                busy_d = 1'b1;
                if (is_div_op(op_q)) begin
                    if (!div_diff[WIDTH])
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                count_d = count_q + CW'(1);
                if (count_q == CNT_LAST)
                    state_d = S_FIXUP;
            end
            S_FIXUP: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                case (op_q)
                    MD_MUL:            result_d = fix_out[WIDTH-1:0];
                    MD_SMULH, MD_UMULH: result_d = fix_out[2*WIDTH-1:WIDTH];
                    MD_SDIV, MD_UDIV:  result_d = fix_out[WIDTH-1:0];
                    default:           result_d = '0;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            op_q       <= MD_MUL;
            sign_q     <= 1'b0;
            div_zero_q <= 1'b0;
            count_q    <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            sign_q     <= sign_d;
            div_zero_q <= div_zero_d;
            count_q    <= count_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=64 with latency checks on every op.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [63:0] operand_a = '0;
    logic [63:0] operand_b = '0;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int tests = 0;
    int fails = 0;

    mul_div_unit #(.WIDTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Called at #1 after the accept edge; optionally pulses start at cycle pulse_at.
    task automatic wait_done(input string tag, input logic [63:0] exp, input int pulse_at,
                             input logic [2:0] p_op, input logic [63:0] p_a, input logic [63:0] p_b);
        int cycles = 0;
        int busy_cnt = 0;
        while (done !== 1'b1 && cycles < 200) begin
            if (busy === 1'b1) busy_cnt++;
            @(posedge clk);
            #1;
            start = 1'b0;
            cycles++;
            if (cycles == pulse_at) begin
                start = 1'b1; op = p_op; operand_a = p_a; operand_b = p_b;
            end
        end
        chk({tag, " done_edge"}, 64'(cycles + 1), 64'd66);
        chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'd65);
        chk({tag, " result"}, result, exp);
        chk({tag, " busy_in_done"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic issue(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        operand_a = '1; operand_b = '1; op = 3'd7;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp);
        issue(o, a, b);
        wait_done(tag, exp, -1, 3'd0, 64'd0, 64'd0);
        @(posedge clk);
        #1;
        chk({tag, " done_one_cycle"}, {63'd0, done}, 64'd0);
        chk({tag, " result_held"}, result, exp);
    endtask

    initial begin
        int cyc;
        #12;
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset result", result, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mul 7*-3", MD_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("umulh", MD_UMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1);
        run_op("smulh", MD_SMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("sdiv -7/2", MD_SDIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("udiv 100/7", MD_UDIV, 64'd100, 64'd7, 64'd14);
        run_op("sdiv 7/-2", MD_SDIV, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("udiv 5/0", MD_UDIV, 64'd5, 64'd0, 64'd0);
        run_op("sdiv min/-1", MD_SDIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000);
        run_op("mul big", MD_MUL, 64'h0000_0001_0000_0003, 64'h0000_0000_0000_0010,
               64'h0000_0010_0000_0030);
        run_op("undef op", 3'd5, 64'd9, 64'd3, 64'd0);

        // Start while busy is ignored; start in the done cycle is accepted.
        issue(MD_MUL, 64'd6, 64'd7);
        wait_done("ignored start", 64'd42, 10, MD_UDIV, 64'd9, 64'd3);
        start = 1'b1; op = MD_UDIV; operand_a = 64'd9; operand_b = 64'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b accepted busy", {63'd0, busy}, 64'd1);
        chk("b2b result held", result, 64'd42);
        wait_done("b2b udiv 9/3", 64'd3, -1, 3'd0, 64'd0, 64'd0);

        // Asynchronous reset in the middle of ITER.
        issue(MD_MUL, 64'd5, 64'd5);
        for (int i = 1; i < 30; i++) begin
            @(posedge clk);
            #1;
        end
        chk("pre-reset busy", {63'd0, busy}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async rst busy", {63'd0, busy}, 64'd0);
        chk("async rst done", {63'd0, done}, 64'd0);
        chk("async rst result", result, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) cyc++;
        end
        chk("no done after abort", 64'(cyc), 64'd0);
        run_op("mul 2*3", MD_MUL, 64'd2, 64'd3, 64'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
